// File: rtl/instr_seq_pkg.sv
// -----------------------------------------------------------------------------
// instr_seq_pkg
//   Shared types for the instruction sequencer slice.
//   - instr_t      : 9-bit decoder instruction {op, out_sel, in_sel}
//   - INSTR_END    : terminator word; never issued, also the idle bus value
//   - seq_state_t  : sequencer FSM states
//   - is_end()     : true when a word is the terminator
// -----------------------------------------------------------------------------
package instr_seq_pkg;

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] out_sel;
        logic [2:0] in_sel;
    } instr_t;

    localparam instr_t INSTR_END = 9'h000;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } seq_state_t;

    function automatic logic is_end(input instr_t w);
        return (w == INSTR_END);
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// -----------------------------------------------------------------------------
// instr_sequencer_if
//   Host-side bus of the instruction sequencer.
//   master : host/bench (program load, length, start/abort; observes status)
//   slave  : sequencer
//   Signals:
//     prog_we, prog_addr[AW-1:0], prog_wdata : program write port
//     prog_len[AW:0]                          : words to run (0..DEPTH)
//     start, abort                            : run control
//     instr_out, instr_valid                  : instruction stream to decoder
//     pc[AW-1:0], busy, done, err             : status
// -----------------------------------------------------------------------------
interface instr_sequencer_if
    import instr_seq_pkg::*;
#(
    parameter int AW = 4
);

    logic          prog_we;
    logic [AW-1:0] prog_addr;
    instr_t        prog_wdata;
    logic [AW:0]   prog_len;
    logic          start;
    logic          abort;
    instr_t        instr_out;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output prog_we, prog_addr, prog_wdata, prog_len, start, abort,
        input  instr_out, instr_valid, pc, busy, done, err
    );

    modport slave (
        input  prog_we, prog_addr, prog_wdata, prog_len, start, abort,
        output instr_out, instr_valid, pc, busy, done, err
    );

endinterface

// File: rtl/instr_prog_mem.sv
// -----------------------------------------------------------------------------
// instr_prog_mem
//   DEPTH x 9-bit program store. One synchronous write port, one
//   asynchronous (combinational) read port. Contents are not reset.
//   Ports:
//     i_clk            clock
//     i_we             write enable
//     i_waddr[AW-1:0]  write address
//     i_wdata          write data
//     i_raddr[AW-1:0]  read address
//     o_rdata          read data (combinational)
// -----------------------------------------------------------------------------
module instr_prog_mem
    import instr_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  instr_t        i_wdata,
    input  logic [AW-1:0] i_raddr,
    output instr_t        o_rdata
);

    instr_t r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//   Program sequencer for the 9-bit instruction decoder. Holds a program of
//   DEPTH words and, on start, issues one instruction every HOLD+1 cycles,
//   holding each stable on instr_out. A word of 9'h000 or reaching prog_len
//   ends the run with a one-cycle done pulse.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    instr_sequencer_if.slave (program port, control, status)
//   Parameters:
//     DEPTH  program words, AW address width, HOLD wait cycles per issue (>=1)
// -----------------------------------------------------------------------------
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int HOLD  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    instr_sequencer_if.slave        bus
);

    // Counter only needs to hold HOLD-1.
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    seq_state_t    r_state;
    logic [AW:0]   r_pc;       // one bit wider so pc==DEPTH is reachable without wrap
    logic [AW:0]   r_len;
    logic [CW-1:0] r_cnt;
    instr_t        r_instr;
    logic          r_valid;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    logic          w_mem_we;
    instr_t        w_rd_data;
    logic          w_run;

    // Program may only change while idle; writes at other times are dropped.
    assign w_mem_we = bus.prog_we && (r_state == IDLE);
    assign w_run    = (r_state == ISSUE) || (r_state == WAIT);

    instr_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_mem_we),
        .i_waddr (bus.prog_addr),
        .i_wdata (bus.prog_wdata),
        .i_raddr (r_pc[AW-1:0]),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_instr <= INSTR_END;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= bus.prog_we && (r_state != IDLE);

            // Abort takes priority over every other transition of a run.
            if (w_run && bus.abort) begin
                r_state <= IDLE;
                r_instr <= INSTR_END;
                r_pc    <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.start && !bus.abort) begin
                            r_len   <= bus.prog_len;
                            r_pc    <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if ((r_pc >= r_len) || is_end(w_rd_data)) begin
                            r_instr <= INSTR_END;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_instr <= w_rd_data;
                            r_valid <= 1'b1;
                            r_cnt   <= CW'(HOLD - 1);
                            r_state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (r_cnt == '0) begin
                            r_pc    <= r_pc + (AW+1)'(1);
                            r_state <= ISSUE;
                        end else begin
                            r_cnt   <= r_cnt - CW'(1);
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.instr_out   = r_instr;
    assign bus.instr_valid = r_valid;
    assign bus.pc          = r_pc[AW-1:0];
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err         = r_err;

endmodule
